decode_ctrl_cmp: RTL and testbench

DECODE_CTRL_CMP -- requirements
Module: decode_ctrl_cmp

---
 rtl/decode_ctrl_cmp_pkg.sv | 55 +++++
 rtl/decode_ctrl_cmp_cmp.sv | 30 +++
 rtl/decode_ctrl_cmp.sv | 127 ++++++++++++
 tb/tb_decode_ctrl_cmp.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/decode_ctrl_cmp_pkg.sv
// rtl/decode_ctrl_cmp_pkg.sv - shared field ranges, opcode/funct codes and instruction indices
// Class masks are spans over the index order below, so reorder with care.
package decode_ctrl_cmp_pkg;

   localparam int NUM_INSTR = 53;

   localparam int OP_HI = 31, OP_LO = 26;
   localparam int RS_HI = 25, RS_LO = 21;
   localparam int RT_HI = 20, RT_LO = 16;
   localparam int FN_HI = 5,  FN_LO = 0;

   localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J    = 6'h02, OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ  = 6'h07;
   localparam logic [5:0] OP_ADDI    = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b;
   localparam logic [5:0] OP_ANDI    = 6'h0c, OP_ORI    = 6'h0d, OP_XORI = 6'h0e, OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_COP0    = 6'h10;
   localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24, OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2b;

   localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03, F_SLLV = 6'h04;
   localparam logic [5:0] F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR   = 6'h08, F_JALR = 6'h09;
   localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
   localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1a, F_DIVU = 6'h1b;
   localparam logic [5:0] F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB  = 6'h22, F_SUBU = 6'h23;
   localparam logic [5:0] F_AND  = 6'h24, F_OR   = 6'h25, F_XOR  = 6'h26, F_NOR  = 6'h27;
   localparam logic [5:0] F_SLT  = 6'h2a, F_SLTU = 6'h2b, F_ERET = 6'h18;

   localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01;
   localparam logic [4:0] RS_MFC0 = 5'h00, RS_MTC0 = 5'h04, RS_CO = 5'h10;

   typedef enum logic [1:0] {RD_NONE = 2'b00, RD_RT = 2'b01, RD_RD = 2'b10, RD_R31 = 2'b11} reg_dst_t;

   localparam int I_ADD = 0, I_ADDU = 1, I_SUB = 2, I_SUBU = 3, I_AND = 4, I_OR = 5, I_XOR = 6;
   localparam int I_NOR = 7, I_SLT = 8, I_SLTU = 9, I_SLL = 10, I_SRL = 11, I_SRA = 12;
   localparam int I_SLLV = 13, I_SRLV = 14, I_SRAV = 15, I_MFHI = 16, I_MFLO = 17, I_JALR = 18;
   localparam int I_MULT = 19, I_MULTU = 20, I_DIV = 21, I_DIVU = 22, I_MTHI = 23, I_MTLO = 24;
   localparam int I_JR = 25, I_ADDI = 26, I_ADDIU = 27, I_SLTI = 28, I_SLTIU = 29, I_ANDI = 30;
   localparam int I_ORI = 31, I_XORI = 32, I_LUI = 33, I_LB = 34, I_LBU = 35, I_LH = 36, I_LHU = 37;
   localparam int I_LW = 38, I_SB = 39, I_SH = 40, I_SW = 41, I_BEQ = 42, I_BNE = 43, I_BLEZ = 44;
   localparam int I_BGTZ = 45, I_BLTZ = 46, I_BGEZ = 47, I_J = 48, I_JAL = 49, I_MFC0 = 50;
   localparam int I_MTC0 = 51, I_ERET = 52;

   function automatic logic [NUM_INSTR-1:0] span(input int lo, input int hi);
      logic [NUM_INSTR-1:0] m;
      m = '0;
      for (int i = lo; i <= hi; i++) m[i] = 1'b1;
      return m;
   endfunction

   localparam logic [NUM_INSTR-1:0] M_RD_RD  = span(I_ADD, I_JALR);
   localparam logic [NUM_INSTR-1:0] M_RD_RT  = span(I_ADDI, I_LW) | span(I_MFC0, I_MFC0);
   localparam logic [NUM_INSTR-1:0] M_EXT    = span(I_ADDI, I_SLTIU) | span(I_LB, I_BGEZ);
   localparam logic [NUM_INSTR-1:0] M_BRANCH = span(I_BEQ, I_BGEZ);

endpackage

// File: rtl/decode_ctrl_cmp_cmp.sv
// rtl/decode_ctrl_cmp_cmp.sv - branch condition comparator (module branch_cmp)
module branch_cmp
   import decode_ctrl_cmp_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic [NUM_INSTR-1:0] ibus,
   input  logic [DW-1:0]        a,
   input  logic [DW-1:0]        b,
   output logic                 cmp_true
);

   logic a_zero;
   logic a_neg;
   logic unused_ibus;

   assign a_zero      = (a == '0);
   assign a_neg       = a[DW-1];
   assign unused_ibus = ^ibus;

   always_comb begin
      cmp_true = (ibus[I_BEQ]  & (a == b))
               | (ibus[I_BNE]  & (a != b))
               | (ibus[I_BLEZ] & (a_neg | a_zero))
               | (ibus[I_BGTZ] & ~a_neg & ~a_zero)
               | (ibus[I_BLTZ] & a_neg)
               | (ibus[I_BGEZ] & ~a_neg);
   end

endmodule

// File: rtl/decode_ctrl_cmp.sv
// rtl/decode_ctrl_cmp.sv - D-stage decoder, branch compare and E-stage bubble register
// Define DECODE_CP0_EN to decode mfc0, mtc0 and eret.
module decode_ctrl_cmp
   import decode_ctrl_cmp_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [31:0]          instr,
   input  logic [DW-1:0]        a,
   input  logic [DW-1:0]        b,
   input  logic                 stall,
   input  logic                 flush,
   output logic [NUM_INSTR-1:0] ibus,
   output logic                 ext_op,
   output logic [1:0]           reg_dst,
   output logic                 is_branch,
   output logic                 imm_jump,
   output logic                 reg_jump,
   output logic                 e_jump,
   output logic                 ins_match,
   output logic                 cmp_true,
   output logic                 branch_taken,
   output logic [NUM_INSTR-1:0] e_ibus,
   output logic [1:0]           e_reg_dst,
   output logic                 e_ins_match
);

   localparam logic [NUM_INSTR-1:0] ONE = {{(NUM_INSTR-1){1'b0}}, 1'b1};

   logic [5:0] op, fn;
   logic [4:0] rt;
   logic       hit;
   int         idx;
   logic       unused_bits;

   assign op = instr[OP_HI:OP_LO];
   assign fn = instr[FN_HI:FN_LO];
   assign rt = instr[RT_HI:RT_LO];

   always_comb begin
      hit = 1'b1;
      idx = 0;
      case (op)
         OP_SPECIAL: case (fn)
            F_ADD:  idx = I_ADD;   F_ADDU:  idx = I_ADDU;  F_SUB:  idx = I_SUB;  F_SUBU: idx = I_SUBU;
            F_AND:  idx = I_AND;   F_OR:    idx = I_OR;    F_XOR:  idx = I_XOR;  F_NOR:  idx = I_NOR;
            F_SLT:  idx = I_SLT;   F_SLTU:  idx = I_SLTU;  F_SLL:  idx = I_SLL;  F_SRL:  idx = I_SRL;
            F_SRA:  idx = I_SRA;   F_SLLV:  idx = I_SLLV;  F_SRLV: idx = I_SRLV; F_SRAV: idx = I_SRAV;
            F_MFHI: idx = I_MFHI;  F_MFLO:  idx = I_MFLO;  F_JALR: idx = I_JALR; F_MULT: idx = I_MULT;
            F_MULTU: idx = I_MULTU; F_DIV:  idx = I_DIV;   F_DIVU: idx = I_DIVU; F_MTHI: idx = I_MTHI;
            F_MTLO: idx = I_MTLO;  F_JR:    idx = I_JR;
            default: hit = 1'b0;
         endcase
         OP_REGIMM: case (rt)
            RT_BLTZ: idx = I_BLTZ;
            RT_BGEZ: idx = I_BGEZ;
            default: hit = 1'b0;
         endcase
         OP_ADDI:  idx = I_ADDI;  OP_ADDIU: idx = I_ADDIU; OP_SLTI: idx = I_SLTI; OP_SLTIU: idx = I_SLTIU;
         OP_ANDI:  idx = I_ANDI;  OP_ORI:   idx = I_ORI;   OP_XORI: idx = I_XORI; OP_LUI:   idx = I_LUI;
         OP_LB:    idx = I_LB;    OP_LBU:   idx = I_LBU;   OP_LH:   idx = I_LH;   OP_LHU:   idx = I_LHU;
         OP_LW:    idx = I_LW;    OP_SB:    idx = I_SB;    OP_SH:   idx = I_SH;   OP_SW:    idx = I_SW;
         OP_BEQ:   idx = I_BEQ;   OP_BNE:   idx = I_BNE;   OP_BLEZ: idx = I_BLEZ; OP_BGTZ:  idx = I_BGTZ;
         OP_J:     idx = I_J;     OP_JAL:   idx = I_JAL;
`ifdef DECODE_CP0_EN
         OP_COP0: begin
            if (instr[RS_HI:RS_LO] == RS_MFC0)                     idx = I_MFC0;
            else if (instr[RS_HI:RS_LO] == RS_MTC0)                idx = I_MTC0;
            else if (instr[RS_HI:RS_LO] == RS_CO && fn == F_ERET)  idx = I_ERET;
            else                                                   hit = 1'b0;
         end
`endif
         default: hit = 1'b0;
      endcase
   end

`ifdef DECODE_CP0_EN
   assign unused_bits = ^instr[15:6];
   assign e_jump      = ibus[I_ERET];
`else
   assign unused_bits = ^{instr[RS_HI:RS_LO], instr[15:6]};
   assign e_jump      = 1'b0;
`endif

   assign ibus      = hit ? (ONE << idx) : '0;
   assign ins_match = |ibus;
   assign ext_op    = |(ibus & M_EXT);
   assign is_branch = |(ibus & M_BRANCH);
   assign imm_jump  = ibus[I_J] | ibus[I_JAL];
   assign reg_jump  = ibus[I_JR] | ibus[I_JALR];

   always_comb begin
      reg_dst = RD_NONE;
      if (|(ibus & M_RD_RD))      reg_dst = RD_RD;
      else if (|(ibus & M_RD_RT)) reg_dst = RD_RT;
      else if (ibus[I_JAL])       reg_dst = RD_R31;
   end

   branch_cmp #(.DW(DW)) u_cmp (
      .ibus     (ibus),
      .a        (a),
      .b        (b),
      .cmp_true (cmp_true)
   );

   assign branch_taken = cmp_true & is_branch;

   // stall and flush both insert a bubble into E
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         e_ibus      <= '0;
         e_reg_dst   <= RD_NONE;
         e_ins_match <= 1'b0;
      end else if (flush || stall) begin
         e_ibus      <= '0;
         e_reg_dst   <= RD_NONE;
         e_ins_match <= 1'b0;
      end else begin
         e_ibus      <= ibus;
         e_reg_dst   <= reg_dst;
         e_ins_match <= ins_match;
      end
   end

endmodule

// File: tb/tb_decode_ctrl_cmp.sv
// tb/tb_decode_ctrl_cmp.sv - randomized self-checking bench against a table-driven decode model
module tb_decode_ctrl_cmp;
   import decode_ctrl_cmp_pkg::NUM_INSTR;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [31:0]          instr, a, b;
   logic                 stall, flush;
   logic [NUM_INSTR-1:0] ibus, e_ibus;
   logic [1:0]           reg_dst, e_reg_dst;
   logic ext_op, is_branch, imm_jump, reg_jump, e_jump, ins_match, cmp_true, branch_taken, e_ins_match;

   int checks = 0;
   int errors = 0;

   decode_ctrl_cmp #(.DW(32)) dut (
      .clk(clk), .reset(reset), .instr(instr), .a(a), .b(b), .stall(stall), .flush(flush),
      .ibus(ibus), .ext_op(ext_op), .reg_dst(reg_dst), .is_branch(is_branch), .imm_jump(imm_jump),
      .reg_jump(reg_jump), .e_jump(e_jump), .ins_match(ins_match), .cmp_true(cmp_true),
      .branch_taken(branch_taken), .e_ibus(e_ibus), .e_reg_dst(e_reg_dst), .e_ins_match(e_ins_match)
   );

   always #5 clk = ~clk;

   // cls: 0 none, 1 branch, 2 j/jal, 3 jr/jalr, 4 eret; ck: 0 none, 1 eq, 2 ne, 3 lez, 4 gtz, 5 ltz, 6 gez
   typedef struct {int op; int fn; int rt; int rs; int rd; int ext; int cls; int ck;} desc_t;
   desc_t tbl[$];

`ifdef DECODE_CP0_EN
   localparam int NDEC = 53;
`else
   localparam int NDEC = 50;
`endif

   task automatic add(input int op, fn, rt, rs, rd, ext, cls, ck);
      desc_t d;
      d.op = op; d.fn = fn; d.rt = rt; d.rs = rs; d.rd = rd; d.ext = ext; d.cls = cls; d.ck = ck;
      tbl.push_back(d);
   endtask

   task automatic build_table();
      int rfn[16] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2a, 'h2b, 'h00, 'h02, 'h03, 'h04, 'h06, 'h07};
      int nfn[6]  = '{'h18, 'h19, 'h1a, 'h1b, 'h11, 'h13};
      int iop[13] = '{'h08, 'h09, 'h0a, 'h0b, 'h0c, 'h0d, 'h0e, 'h0f, 'h20, 'h24, 'h21, 'h25, 'h23};
      foreach (rfn[i]) add(0, rfn[i], -1, -1, 2, 0, 0, 0);
      add(0, 'h10, -1, -1, 2, 0, 0, 0);
      add(0, 'h12, -1, -1, 2, 0, 0, 0);
      add(0, 'h09, -1, -1, 2, 0, 3, 0);
      foreach (nfn[i]) add(0, nfn[i], -1, -1, 0, 0, 0, 0);
      add(0, 'h08, -1, -1, 0, 0, 3, 0);
      foreach (iop[i]) add(iop[i], -1, -1, -1, 1, (iop[i] >= 'h0c && iop[i] <= 'h0f) ? 0 : 1, 0, 0);
      add('h28, -1, -1, -1, 0, 1, 0, 0);
      add('h29, -1, -1, -1, 0, 1, 0, 0);
      add('h2b, -1, -1, -1, 0, 1, 0, 0);
      for (int c = 1; c <= 4; c++) add(3 + c, -1, -1, -1, 0, 1, 1, c);
      add(1, -1, 0, -1, 0, 1, 1, 5);
      add(1, -1, 1, -1, 0, 1, 1, 6);
      add(2, -1, -1, -1, 0, 0, 2, 0);
      add(3, -1, -1, -1, 3, 0, 2, 0);
      add('h10, -1, -1, 'h00, 1, 0, 0, 0);
      add('h10, -1, -1, 'h04, 0, 0, 0, 0);
      add('h10, 'h18, -1, 'h10, 0, 0, 4, 0);
   endtask

   function automatic int ref_find(input logic [31:0] w);
      for (int i = 0; i < NDEC; i++)
         if (int'(w[31:26]) == tbl[i].op &&
             (tbl[i].fn < 0 || int'(w[5:0]) == tbl[i].fn) &&
             (tbl[i].rt < 0 || int'(w[20:16]) == tbl[i].rt) &&
             (tbl[i].rs < 0 || int'(w[25:21]) == tbl[i].rs))
            return i;
      return -1;
   endfunction

   function automatic logic ref_cmp(input int ck, input logic [31:0] x, input logic [31:0] y);
      case (ck)
         1: return x == y;
         2: return x != y;
         3: return $signed(x) <= 0;
         4: return $signed(x) > 0;
         5: return x[31];
         6: return !x[31];
         default: return 1'b0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (instr=%08h a=%08h b=%08h)", tag, got, exp, instr, a, b);
      end
   endtask

   task automatic verify(output logic [63:0] xi, output logic [1:0] xrd, output logic xm);
      int   k;
      logic xc;
      k   = ref_find(instr);
      xm  = (k >= 0);
      xi  = xm ? (64'd1 << k) : 64'd0;
      xrd = xm ? 2'(tbl[k].rd) : 2'b00;
      xc  = xm ? ref_cmp(tbl[k].ck, a, b) : 1'b0;
      check("ibus", {11'b0, ibus}, xi);
      check("ins_match", 64'(ins_match), 64'(xm));
      check("reg_dst", 64'(reg_dst), 64'(xrd));
      check("ext_op", 64'(ext_op), xm ? 64'(tbl[k].ext) : 64'd0);
      check("is_branch", 64'(is_branch), 64'(xm && tbl[k].cls == 1));
      check("imm_jump", 64'(imm_jump), 64'(xm && tbl[k].cls == 2));
      check("reg_jump", 64'(reg_jump), 64'(xm && tbl[k].cls == 3));
      check("e_jump", 64'(e_jump), 64'(xm && tbl[k].cls == 4));
      check("cmp_true", 64'(cmp_true), 64'(xc));
      check("branch_taken", 64'(branch_taken), 64'(xc && tbl[k].cls == 1));
   endtask

   task automatic vec(input logic [31:0] w, input logic [31:0] av, input logic [31:0] bv);
      logic [63:0] xi;
      logic [1:0]  xrd;
      logic        xm;
      instr = w; a = av; b = bv;
      #1;
      verify(xi, xrd, xm);
   endtask

   task automatic check_e(input string tag, input logic [63:0] xi, input logic [1:0] xrd, input logic xm);
      check({tag, "_e_ibus"}, {11'b0, e_ibus}, xi);
      check({tag, "_e_reg_dst"}, 64'(e_reg_dst), 64'(xrd));
      check({tag, "_e_ins_match"}, 64'(e_ins_match), 64'(xm));
   endtask

   initial begin
      logic [63:0] xi;
      logic [1:0]  xrd;
      logic        xm;
      logic [31:0] w;
      int          k;
      build_table();
      reset = 1'b0; stall = 1'b0; flush = 1'b0;
      instr = 32'h0022_1821; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1 check_e("reset", 64'd0, 2'b00, 1'b0);
      @(negedge clk) reset = 1'b1;

      vec(32'h1022_0003, 32'd5, 32'd5);
      check("beq_eq_cmp", 64'(cmp_true), 64'd1);
      check("beq_eq_taken", 64'(branch_taken), 64'd1);
      vec(32'h1022_0003, 32'd5, 32'd6);
      check("beq_ne_cmp", 64'(cmp_true), 64'd0);
      vec(32'h0420_0001, 32'h8000_0000, 32'd0);
      check("bltz_neg", 64'(cmp_true), 64'd1);
      vec(32'h0421_0001, 32'd0, 32'd0);
      check("bgez_zero", 64'(cmp_true), 64'd1);
      vec(32'h1C20_0001, 32'd0, 32'd0);
      check("bgtz_zero", 64'(cmp_true), 64'd0);
      vec(32'h1820_0001, 32'd0, 32'd0);
      check("blez_zero", 64'(cmp_true), 64'd1);
      vec(32'h0C00_0010, 32'd0, 32'd0);
      check("jal_imm_jump", 64'(imm_jump), 64'd1);
      check("jal_reg_dst", 64'(reg_dst), 64'd3);
      vec(32'h0040_0008, 32'd0, 32'd0);
      check("jr_reg_jump", 64'(reg_jump), 64'd1);
      check("jr_reg_dst", 64'(reg_dst), 64'd0);
      vec(32'h3422_0010, 32'd0, 32'd0);
      check("ori_reg_dst", 64'(reg_dst), 64'd1);
      check("ori_ext", 64'(ext_op), 64'd0);
      vec(32'h2422_0010, 32'd0, 32'd0);
      check("addiu_ext", 64'(ext_op), 64'd1);
      vec(32'hFC00_0000, 32'd0, 32'd0);
      check("bad_match", 64'(ins_match), 64'd0);
      check("bad_ibus", {11'b0, ibus}, 64'd0);
      vec(32'h0000_0000, 32'd0, 32'd0);
      check("zero_is_sll", {11'b0, ibus}, 64'd1 << 10);
      vec(32'h4200_0018, 32'd0, 32'd0);
`ifdef DECODE_CP0_EN
      check("eret_e_jump", 64'(e_jump), 64'd1);
`else
      check("eret_nomatch", 64'(ins_match), 64'd0);
`endif

      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         w = $urandom;
         if ($urandom_range(0, 7) != 0) begin
            k = $urandom_range(0, 52);
            w[31:26] = 6'(tbl[k].op);
            if (tbl[k].fn >= 0) w[5:0]   = 6'(tbl[k].fn);
            if (tbl[k].rt >= 0) w[20:16] = 5'(tbl[k].rt);
            if (tbl[k].rs >= 0) w[25:21] = 5'(tbl[k].rs);
         end
         case ($urandom_range(0, 3))
            0: begin a = $urandom; b = a; end
            1: begin a = 32'd0; b = $urandom; end
            2: begin a = $urandom; b = $urandom; end
            default: begin a = 32'($urandom_range(0, 2)) - 32'd1; b = $urandom_range(0, 1); end
         endcase
         instr = w;
         stall = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 4) == 0);
         #1 verify(xi, xrd, xm);
         if (stall || flush) begin xi = '0; xrd = 2'b00; xm = 1'b0; end
         @(posedge clk);
         #1 check_e("rand", xi, xrd, xm);
      end

      @(negedge clk);
      instr = 32'h0022_1821; stall = 1'b0; flush = 1'b0;
      @(posedge clk);
      #1 check_e("addu_load", 64'd2, 2'b10, 1'b1);
      @(negedge clk);
      #2 reset = 1'b0;
      #1 check_e("async_rst", 64'd0, 2'b00, 1'b0);
      check("rst_comb_match", 64'(ins_match), 64'd1);
      @(posedge clk);
      #1 check_e("held_rst", 64'd0, 2'b00, 1'b0);
      @(negedge clk) begin reset = 1'b1; stall = 1'b1; end
      @(posedge clk);
      #1 check_e("stall_after_rst", 64'd0, 2'b00, 1'b0);
      @(negedge clk) stall = 1'b0;
      @(posedge clk);
      #1 check_e("reload", 64'd2, 2'b10, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
